// File: rtl/sensor_pulse_gen_pkg.sv
// Shared motor package: controller state encoding and default bus widths
// for the sensor pulse generator and its per-motor channels.
package sensor_pulse_gen_pkg;

  // Default widths for pulse-count targets/counters and the half-period setting.
  localparam int unsigned DEF_CNT_W = 16;
  localparam int unsigned DEF_PER_W = 16;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } motor_state_t;

endpackage : sensor_pulse_gen_pkg

// File: rtl/pulse_channel.sv
// One emulated motor sensor channel: emits target pulses, each a low phase
// followed by a high phase of half_per cycles, counting rising edges.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   launch        - start-of-run strobe; latches target_in and clears state
//   run           - controller is in RUN; channel advances while set
//   halt          - abort request; forces m low and freezes the count
//   half_per      - latched half period (always >= 1 while run is set)
//   target_in     - pulse target, sampled on launch
//   m             - pulse output (registered)
//   emitted       - rising edges produced so far (registered)
//   fin_next_c    - channel will be finished after the current edge
module pulse_channel
  import sensor_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned PER_W = DEF_PER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             launch,
  input  logic             run,
  input  logic             halt,
  input  logic [PER_W-1:0] half_per,
  input  logic [CNT_W-1:0] target_in,
  output logic             m,
  output logic [CNT_W-1:0] emitted,
  output logic             fin_next_c
);

  logic [PER_W-1:0] phase_cnt;
  logic [CNT_W-1:0] target;
  logic             finished;
  logic             phase_end_c;
  logic             last_fall_c;

  // Last cycle of the current low or high phase.
  assign phase_end_c = (phase_cnt == (half_per - PER_W'(1)));

  // End of the high phase of the final pulse: the channel completes here.
  assign last_fall_c = run && !finished && m && phase_end_c && (emitted == target);

  // A zero target is complete as soon as the run is launched.
  assign fin_next_c = launch ? (target_in == '0) : (finished || last_fall_c);

  // Phase counter, output toggle, edge counter and finished flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_cnt <= '0;
      target    <= '0;
      finished  <= 1'b0;
      m         <= 1'b0;
      emitted   <= '0;
    end else if (launch) begin
      phase_cnt <= '0;
      target    <= target_in;
      finished  <= (target_in == '0);
      m         <= 1'b0;
      emitted   <= '0;
    end else if (run && halt) begin
      m <= 1'b0;
    end else if (run && !finished) begin
      if (phase_end_c) begin
        phase_cnt <= '0;
        if (!m) begin
          // A rise only happens while emitted < target, so no wrap.
          m       <= 1'b1;
          emitted <= emitted + CNT_W'(1);
        end else begin
          m <= 1'b0;
          if (emitted == target) begin
            finished <= 1'b1;
          end
        end
      end else begin
        phase_cnt <= phase_cnt + PER_W'(1);
      end
    end
  end

endmodule : pulse_channel

// File: rtl/sensor_pulse_gen.sv
// Dual motor sensor pulse generator. On an accepted start it latches a shared
// half period and two pulse targets, then drives two independent pulse trains
// until both finish or stop aborts the run.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   start, stop                 - run request (IDLE only) / abort (stop wins)
//   half_period                 - cycles per low and per high phase (0 acts as 1)
//   pulse_count1, pulse_count2  - pulse targets for m1 / m2
//   m1, m2                      - emulated sensor pulse trains
//   emitted1, emitted2          - rising edges produced in current/last run
//   busy                        - high while running
//   done                        - one-cycle end-of-run pulse
module sensor_pulse_gen
  import sensor_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned PER_W = DEF_PER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [PER_W-1:0] half_period,
  input  logic [CNT_W-1:0] pulse_count1,
  input  logic [CNT_W-1:0] pulse_count2,
  output logic             m1,
  output logic             m2,
  output logic [CNT_W-1:0] emitted1,
  output logic [CNT_W-1:0] emitted2,
  output logic             busy,
  output logic             done
);

  motor_state_t     state;
  logic [PER_W-1:0] h_q;
  logic             launch_c;
  logic             run_c;
  logic             fin1_c;
  logic             fin2_c;

  // Stop has priority over start; start is only honoured in IDLE.
  assign launch_c = (state == ST_IDLE) && start && !stop;
  assign run_c    = (state == ST_RUN);

  pulse_channel #(
    .CNT_W (CNT_W),
    .PER_W (PER_W)
  ) u_ch1 (
    .clk        (clk),
    .reset      (reset),
    .launch     (launch_c),
    .run        (run_c),
    .halt       (stop),
    .half_per   (h_q),
    .target_in  (pulse_count1),
    .m          (m1),
    .emitted    (emitted1),
    .fin_next_c (fin1_c)
  );

  pulse_channel #(
    .CNT_W (CNT_W),
    .PER_W (PER_W)
  ) u_ch2 (
    .clk        (clk),
    .reset      (reset),
    .launch     (launch_c),
    .run        (run_c),
    .halt       (stop),
    .half_per   (h_q),
    .target_in  (pulse_count2),
    .m          (m2),
    .emitted    (emitted2),
    .fin_next_c (fin2_c)
  );

  // Run controller; busy and done are registered copies of the next state so
  // they track (state == RUN) and (state == DONE) exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      h_q   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (launch_c) begin
            h_q <= (half_period == '0) ? PER_W'(1) : half_period;
            // Two zero targets complete at launch and skip RUN entirely.
            if (fin1_c && fin2_c) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop || (fin1_c && fin2_c)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule : sensor_pulse_gen

// File: tb/tb_sensor_pulse_gen.sv
// Self-checking bench for sensor_pulse_gen: a cycle model built from the
// pulse-timing formulas, a per-cycle compare process, and directed scenarios
// with hand-computed literal expectations.
module tb_sensor_pulse_gen;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned PER_W = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic             stop;
  logic [PER_W-1:0] half_period;
  logic [CNT_W-1:0] pulse_count1;
  logic [CNT_W-1:0] pulse_count2;
  logic             m1;
  logic             m2;
  logic [CNT_W-1:0] emitted1;
  logic [CNT_W-1:0] emitted2;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  sensor_pulse_gen #(
    .CNT_W (CNT_W),
    .PER_W (PER_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .half_period  (half_period),
    .pulse_count1 (pulse_count1),
    .pulse_count2 (pulse_count2),
    .m1           (m1),
    .m2           (m2),
    .emitted1     (emitted1),
    .emitted2     (emitted2),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int MS_IDLE = 0;
  localparam int MS_RUN  = 1;
  localparam int MS_DONE = 2;

  int mst = MS_IDLE;
  int mt, mh, mn1, mn2;
  int xe1 = 0, xe2 = 0;
  bit xm1 = 0, xm2 = 0;

  // Rising edges seen by cycle t of a run (t = 0 is the first RUN cycle).
  function automatic int pulses(input int t, input int h, input int n);
    int p;
    p = (t + h) / (2 * h);
    return (p > n) ? n : p;
  endfunction

  // High during odd half-periods, only within the first n pulses.
  function automatic bit level(input int t, input int h, input int n);
    return (t < 2 * n * h) && (((t / h) % 2) == 1);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mst = MS_IDLE; xe1 = 0; xe2 = 0; xm1 = 0; xm2 = 0;
    end else begin
      case (mst)
        MS_IDLE: if (start && !stop) begin
          mh  = (half_period == 0) ? 1 : int'(half_period);
          mn1 = int'(pulse_count1);
          mn2 = int'(pulse_count2);
          mt  = 0; xe1 = 0; xe2 = 0; xm1 = 0; xm2 = 0;
          mst = (mn1 == 0 && mn2 == 0) ? MS_DONE : MS_RUN;
        end
        MS_RUN: if (stop) begin
          xm1 = 0; xm2 = 0; mst = MS_DONE;
        end else begin
          mt++;
          xm1 = level(mt, mh, mn1); xe1 = pulses(mt, mh, mn1);
          xm2 = level(mt, mh, mn2); xe2 = pulses(mt, mh, mn2);
          if (mt >= 2 * mn1 * mh && mt >= 2 * mn2 * mh) mst = MS_DONE;
        end
        default: mst = MS_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_m1", 32'(m1), 32'(xm1));
      check("cyc_m2", 32'(m2), 32'(xm2));
      check("cyc_emitted1", 32'(emitted1), 32'(xe1));
      check("cyc_emitted2", 32'(emitted2), 32'(xe2));
      check("cyc_busy", 32'(busy), 32'(mst == MS_RUN));
      check("cyc_done", 32'(done), 32'(mst == MS_DONE));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a one-cycle start; returns at the sample point of cycle k+1.
  // Inputs are scrambled afterwards to show the run uses latched values.
  task automatic launch(input int h, input int n1, input int n2);
    half_period  = PER_W'(h);
    pulse_count1 = CNT_W'(n1);
    pulse_count2 = CNT_W'(n2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    half_period  = PER_W'(7);
    pulse_count1 = CNT_W'(5);
    pulse_count2 = CNT_W'(9);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    half_period = '0; pulse_count1 = '0; pulse_count2 = '0;
    step(2);
    cmp_en = 1'b1;
    check("rst_m1", 32'(m1), 0);
    check("rst_m2", 32'(m2), 0);
    check("rst_emitted1", 32'(emitted1), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b0;
    step(2);

    // H=1, N1=N2=1
    launch(1, 1, 1);
    check("s1_busy_k1", 32'(busy), 1);
    check("s1_m1_k1", 32'(m1), 0);
    step(1);
    check("s1_m1_k2", 32'(m1), 1);
    check("s1_m2_k2", 32'(m2), 1);
    check("s1_e1_k2", 32'(emitted1), 1);
    check("s1_model_e2_k2", 32'(xe2), 1);
    step(1);
    check("s1_done_k3", 32'(done), 1);
    check("s1_busy_k3", 32'(busy), 0);
    check("s1_m1_k3", 32'(m1), 0);
    step(1);
    check("s1_done_k4", 32'(done), 0);
    step(2);

    // H=3, N1=4, N2=2
    launch(3, 4, 2);
    step(11);
    check("s2_m2_k12", 32'(m2), 1);
    step(1);
    check("s2_m2_k13", 32'(m2), 0);
    check("s2_e2_k13", 32'(emitted2), 2);
    check("s2_busy_k13", 32'(busy), 1);
    step(11);
    check("s2_m1_k24", 32'(m1), 1);
    check("s2_model_m1_k24", 32'(xm1), 1);
    step(1);
    check("s2_done_k25", 32'(done), 1);
    check("s2_e1_k25", 32'(emitted1), 4);
    check("s2_e2_k25", 32'(emitted2), 2);
    step(2);

    // half_period=0 behaves as 1; N2=0 never pulses
    launch(0, 2, 0);
    step(3);
    check("s3_m1_k4", 32'(m1), 1);
    check("s3_e1_k4", 32'(emitted1), 2);
    step(1);
    check("s3_done_k5", 32'(done), 1);
    check("s3_e2_k5", 32'(emitted2), 0);
    check("s3_model_done_k5", 32'(mst == MS_DONE), 1);
    step(2);

    // H=2, N=10, stop during cycle k+9
    launch(2, 10, 10);
    step(8);
    check("s4_e1_k9", 32'(emitted1), 2);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("s4_m1_k10", 32'(m1), 0);
    check("s4_m2_k10", 32'(m2), 0);
    check("s4_done_k10", 32'(done), 1);
    check("s4_e1_k10", 32'(emitted1), 2);
    check("s4_e2_k10", 32'(emitted2), 2);
    step(1);
    check("s4_done_k11", 32'(done), 0);
    check("s4_e2_held", 32'(emitted2), 2);
    step(1);

    // start together with stop in IDLE: no run
    half_period = PER_W'(1); pulse_count1 = CNT_W'(3); pulse_count2 = CNT_W'(3);
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    check("s5_busy_startstop", 32'(busy), 0);
    check("s5_done_startstop", 32'(done), 0);
    step(2);

    // start pulses during RUN and DONE are ignored
    launch(2, 3, 1);
    for (int i = 0; i < 14; i++) begin
      start = (i % 3 == 0);
      step(1);
    end
    start = 1'b0;
    check("s5_busy_after", 32'(busy), 0);
    check("s5_e1_held", 32'(emitted1), 3);
    check("s5_e2_held", 32'(emitted2), 1);
    check("s5_model_e1", 32'(xe1), 3);
    step(1);

    // start held from RUN through DONE is taken in the next IDLE cycle
    half_period = PER_W'(1); pulse_count1 = CNT_W'(1); pulse_count2 = CNT_W'(1);
    start = 1'b1;
    step(3);
    check("s6_done_k3", 32'(done), 1);
    step(1);
    check("s6_busy_k4", 32'(busy), 0);
    step(1);
    start = 1'b0;
    check("s6_busy_k5", 32'(busy), 1);
    check("s6_e1_cleared", 32'(emitted1), 0);
    step(4);

    // reset during cycle k+4 of an H=1, N=8 run
    launch(1, 8, 8);
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("s7_m1", 32'(m1), 0);
    check("s7_m2", 32'(m2), 0);
    check("s7_e1", 32'(emitted1), 0);
    check("s7_e2", 32'(emitted2), 0);
    check("s7_busy", 32'(busy), 0);
    check("s7_done", 32'(done), 0);
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sensor_pulse_gen

// File: doc/sensor_pulse_gen.md
SENSOR_PULSE_GEN -- requirements
Module: sensor_pulse_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of pulse-count targets and emitted counters.
REQ-002 SHALL have parameter PER_W, default 16: width of the half-period setting.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request a run; sampled only in IDLE.
REQ-006 SHALL have port stop, input, 1: abort the current run.
REQ-007 SHALL have port half_period, input, PER_W: clock cycles per low phase and per high phase.
REQ-008 SHALL have port pulse_count1, input, CNT_W: number of pulses to emit on m1.
REQ-009 SHALL have port pulse_count2, input, CNT_W: number of pulses to emit on m2.
REQ-010 SHALL have port m1, output, 1: emulated motor-1 sensor pulse train.
REQ-011 SHALL have port m2, output, 1: emulated motor-2 sensor pulse train.
REQ-012 SHALL have port emitted1, output, CNT_W: rising edges produced on m1 in the current or last run.
REQ-013 SHALL have port emitted2, output, CNT_W: rising edges produced on m2 in the current or last run.
REQ-014 SHALL have port busy, output, 1: high while in state RUN.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at the end of a run.

Function
REQ-016 SHALL implement the states IDLE, RUN and DONE.
REQ-017 SHALL, in IDLE with start=1 and stop=0 at edge k:
- latch half_period as H, with 0 treated as 1;
- latch the targets N1 and N2;
- clear emitted1 and emitted2;
- be in RUN in cycle k+1.
REQ-018 SHALL ignore start while in RUN or DONE, and SHALL ignore input changes after the latch.
REQ-019 SHALL hold each channel x low in cycle k+1 and drive it high in cycles k+1+H*(2j+1) through k+H*(2j+2), for j = 0..Nx-1.
REQ-020 SHALL increment emittedx in the same cycle in which mx first goes high for each pulse; emittedx never exceeds Nx and never wraps.
REQ-021 SHALL mark channel x finished at cycle k+1+2*Nx*H, with mx low from then on; a channel with Nx=0 is finished immediately and mx stays low.
REQ-022 SHALL enter DONE in the cycle in which both channels are finished, assert done for that single cycle, and return to IDLE next cycle.
REQ-023 SHALL, on stop=1 in RUN, force m1 and m2 low and enter DONE on the next cycle, freezing the emitted counts.
REQ-024 SHALL, in IDLE with start and stop asserted together, give stop priority so that no run starts.
REQ-025 SHALL, in DONE, ignore a new start; a start is accepted at the earliest in the following IDLE cycle.
REQ-026 SHALL drive busy as exactly (state == RUN).
REQ-027 SHALL hold emitted1 and emitted2 through IDLE until the next accepted start.
REQ-028 SHALL advance the two channels independently from the common start cycle using the shared H.

Reset
REQ-029 SHALL, when reset=1 at a clock edge, set state to IDLE, m1=m2=0, emitted1=emitted2=0, busy=0, done=0, and all phase counters to 0.
REQ-030 SHALL give reset priority over start and stop; reset mid-RUN aborts the run without asserting done.

Structure
REQ-031 SHALL take the state encoding (IDLE, RUN, DONE) and the default CNT_W and PER_W values from the shared motor package.
REQ-032 SHALL instantiate the sub-module pulse_channel twice, one per motor; each instance contains a phase counter, an output toggle, an emitted counter and a finished flag.
REQ-033 SHALL keep the state machine and done/busy generation in the top level only.

Verification
REQ-034 SHALL cover: H=1, N1=N2=1, start at k -> m1 and m2 high only in cycle k+2; emitted=1 at k+2; done=1 in cycle k+3 only; busy high for cycles k+1..k+2.
REQ-035 SHALL cover: H=3, N1=4, N2=2 -> m2 finished at k+13; m1 keeps toggling until done at k+25; final emitted1=4, emitted2=2.
REQ-036 SHALL cover: half_period=0, N1=2, N2=0 -> behaves as H=1; m2 never high; done at k+5; emitted2=0.
REQ-037 SHALL cover: H=2, N1=N2=10, stop asserted at k+9 -> m1 and m2 low from k+10; done at k+10; emitted1=emitted2=2.
REQ-038 SHALL cover: start together with stop in IDLE -> no RUN, busy stays 0; start asserted during RUN -> ignored, and outputs are unchanged versus a reference run.
REQ-039 SHALL cover: reset at k+4 during a run with H=1, N=8 -> next cycle all outputs 0, state IDLE, no done pulse.
